// File: rtl/conv2_sched.sv
// conv2_sched: address/control sequencer for a 5x5, 3-pass conv2 layer over 8x8 output windows.
// Optional `CONV2_SCHED_STALL_EN adds a stall input that freezes the whole schedule.
module conv2_sched (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
`ifdef CONV2_SCHED_STALL_EN
    input  logic       stall,
`endif
    output logic [7:0] k_addr0,
    output logic [7:0] k_addr1,
    output logic [9:0] in_addr,
    output logic       acc_clr,
    output logic       acc_en,
    output logic       out_we,
    output logic [7:0] out_addr,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, MAC, DRAIN, WRITE, DONE} state_t;

    state_t     state, state_n;
    logic [2:0] kr, kc, row, col;
    logic [2:0] kr_n, kc_n, row_n, col_n;
    logic [1:0] pass, pass_n;
    logic       acc_en_q, acc_clr_q;
    logic       hold;
    logic [9:0] p_w, r_w, c_w, kr_w, kc_w, kidx_w;
    logic [9:0] k0_w, k1_w, in_w;

`ifdef CONV2_SCHED_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    // Addresses are computed from the next-cycle counters so they can be registered.
    assign p_w    = {8'd0, pass_n};
    assign r_w    = {7'd0, row_n};
    assign c_w    = {7'd0, col_n};
    assign kr_w   = {7'd0, kr_n};
    assign kc_w   = {7'd0, kc_n};
    assign kidx_w = kr_w * 10'd5 + kc_w;
    assign k0_w   = p_w * 10'd25 + kidx_w;
    assign k1_w   = 10'd75 + p_w * 10'd25 + kidx_w;
    assign in_w   = p_w * 10'd144 + (r_w + kr_w) * 10'd12 + c_w + kc_w;

    always_comb begin
        state_n = state;
        kr_n    = kr;
        kc_n    = kc;
        row_n   = row;
        col_n   = col;
        pass_n  = pass;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = MAC;
                    kr_n    = 3'd0;
                    kc_n    = 3'd0;
                    row_n   = 3'd0;
                    col_n   = 3'd0;
                    pass_n  = 2'd0;
                end
            end
            MAC: begin
                if (kc == 3'd4) begin
                    kc_n = 3'd0;
                    if (kr == 3'd4) begin
                        kr_n    = 3'd0;
                        state_n = DRAIN;
                    end else begin
                        kr_n = kr + 3'd1;
                    end
                end else begin
                    kc_n = kc + 3'd1;
                end
            end
            DRAIN: state_n = WRITE;
            WRITE: begin
                state_n = MAC;
                if (col == 3'd7) begin
                    col_n = 3'd0;
                    if (row == 3'd7) begin
                        row_n = 3'd0;
                        if (pass == 2'd2) begin
                            pass_n  = 2'd0;
                            state_n = DONE;
                        end else begin
                            pass_n = pass + 2'd1;
                        end
                    end else begin
                        row_n = row + 3'd1;
                    end
                end else begin
                    col_n = col + 3'd1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            kr        <= 3'd0;
            kc        <= 3'd0;
            row       <= 3'd0;
            col       <= 3'd0;
            pass      <= 2'd0;
            acc_en_q  <= 1'b0;
            acc_clr_q <= 1'b0;
            k_addr0   <= 8'd0;
            k_addr1   <= 8'd0;
            in_addr   <= 10'd0;
            out_addr  <= 8'd0;
        end else if (!hold) begin
            state     <= state_n;
            kr        <= kr_n;
            kc        <= kc_n;
            row       <= row_n;
            col       <= col_n;
            pass      <= pass_n;
            // One-cycle memory latency: data for this cycle's address arrives next cycle.
            acc_en_q  <= (state == MAC);
            acc_clr_q <= (state == MAC) && (kr == 3'd0) && (kc == 3'd0);
            if (state_n == MAC) begin
                k_addr0 <= k0_w[7:0];
                k_addr1 <= k1_w[7:0];
                in_addr <= in_w;
            end
            if (state_n == WRITE) begin
                out_addr <= {pass_n, row_n, col_n};
            end
        end
    end

    assign acc_en  = acc_en_q && !hold;
    assign acc_clr = acc_clr_q && !hold;
    assign out_we  = (state == WRITE) && !hold;
    assign done    = (state == DONE) && !hold;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_conv2_sched.sv
// Bench for conv2_sched: timeline model (cycle-since-start arithmetic) checked every cycle,
// plus literal checkpoints for reset, first window, boundary windows, restart and reset mid-run.
module tb_conv2_sched;

    localparam int WIN    = 27;
    localparam int NWIN   = 192;
    localparam int T_LAST = WIN * NWIN;
    localparam int T_DONE = T_LAST + 1;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] k_addr0, k_addr1, out_addr;
    logic [9:0] in_addr;
    logic       acc_clr, acc_en, out_we, busy, done;

    int total = 0;
    int bad   = 0;
    int cur   = 0;
    bit chk_on = 1'b0;

    conv2_sched dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
`ifdef CONV2_SCHED_STALL_EN
        .stall    (stall),
`endif
        .k_addr0  (k_addr0),
        .k_addr1  (k_addr1),
        .in_addr  (in_addr),
        .acc_clr  (acc_clr),
        .acc_en   (acc_en),
        .out_we   (out_we),
        .out_addr (out_addr),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Reference addresses for output window w at kernel index kidx.
    function automatic void win_addr(input int w, input int kidx,
                                     output logic [7:0] a0, output logic [7:0] a1,
                                     output logic [9:0] ai);
        int p, pos, row, col, kr, kc;
        p   = w / 64;
        pos = w % 64;
        row = pos / 8;
        col = pos % 8;
        kr  = kidx / 5;
        kc  = kidx % 5;
        a0  = 8'(p * 25 + kidx);
        a1  = 8'(75 + p * 25 + kidx);
        ai  = 10'(p * 144 + (row + kr) * 12 + col + kc);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Model: m_t counts unstalled cycles since the start edge (1 = first MAC cycle).
    bit         m_run = 1'b0;
    int         m_t   = 0;
    int         m_ph, m_w;
    logic [7:0] h_k0 = '0, h_k1 = '0, h_out = '0;
    logic [9:0] h_in = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_run = 1'b0;
            m_t   = 0;
            h_k0  = '0;
            h_k1  = '0;
            h_in  = '0;
            h_out = '0;
        end else if (!stall) begin
            if (!m_run) begin
                if (start) begin
                    m_run = 1'b1;
                    m_t   = 1;
                end
            end else if (m_t == T_DONE) begin
                m_run = 1'b0;
            end else begin
                m_t++;
            end
            if (m_run && m_t <= T_LAST) begin
                m_ph = (m_t - 1) % WIN;
                m_w  = (m_t - 1) / WIN;
                if (m_ph < 25) win_addr(m_w, m_ph, h_k0, h_k1, h_in);
                if (m_ph == 26) h_out = 8'(m_w);
            end
        end
    end

    always @(negedge clk) begin
        logic [38:0] e, a;
        bit in_win;
        int ph;
        if (chk_on) begin
            in_win = m_run && (m_t <= T_LAST);
            ph     = (m_t - 1) % WIN;
            e = {h_k0, h_k1, h_in,
                 in_win && ph == 1 && !stall,
                 in_win && ph >= 1 && ph <= 25 && !stall,
                 in_win && ph == 26 && !stall,
                 h_out, m_run, m_run && m_t == T_DONE && !stall};
            a = {k_addr0, k_addr1, in_addr, acc_clr, acc_en, out_we, out_addr, busy, done};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL cycle_model t=%0d: got k0=%0d k1=%0d in=%0d clr=%b en=%b we=%b oa=%0d busy=%b done=%b want %0h",
                         m_t, k_addr0, k_addr1, in_addr, acc_clr, acc_en, out_we, out_addr, busy, done, e);
            end
        end
    end

    // Window bookkeeping: 25 acc_en per window, results written in address order.
    int en_cnt = 0, we_cnt = 0, nxt_out = 0, run_we = 0;
    always @(negedge clk) begin
        if (chk_on) begin
            if (!reset) begin
                en_cnt  = 0;
                we_cnt  = 0;
                nxt_out = 0;
            end else begin
                if (acc_en) en_cnt++;
                if (out_we) begin
                    check("window_en_cnt_and_order", {en_cnt[7:0], out_addr}, {8'd25, 8'(nxt_out)});
                    en_cnt = 0;
                    nxt_out++;
                    we_cnt++;
                end
                if (done) begin
                    run_we  = we_cnt;
                    we_cnt  = 0;
                    nxt_out = 0;
                end
            end
        end
    end

    task automatic start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cur = 0;
    endtask

    task automatic at(input int n);
        repeat (n - cur) @(negedge clk);
        cur = n;
    endtask

    task automatic wait_done(input int max_cyc);
        int n = 0;
        while (n < max_cyc && !done) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {63'd0, done}, 64'd1);
    endtask

    logic [7:0] pa0, pa1;
    logic [9:0] pai;

    initial begin
        // Model pins: window pass=1,pos=9 (index 73) at kidx=24.
        win_addr(73, 24, pa0, pa1, pai);
        check("model_pin_k0", {56'd0, pa0}, 64'd49);
        check("model_pin_k1", {56'd0, pa1}, 64'd124);
        check("model_pin_in", {54'd0, pai}, 64'd209);

        chk_on = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {k_addr0, k_addr1, in_addr, acc_clr, acc_en, out_we, out_addr, busy, done}, 64'd0);
        @(posedge clk); #1 reset = 1'b1;
        repeat ($urandom_range(1, 6)) @(posedge clk);

        // Run 1: single start pulse, with ignored random start pokes mid-run.
        start_pulse();
        at(1);
        check("t1_addrs", {k_addr0, k_addr1, in_addr, busy}, {8'd0, 8'd75, 10'd0, 1'b1});
        at(2);
        check("t2_clr_en", {acc_clr, acc_en}, 2'b11);
        at(26);
        check("t26_drain", {out_we, acc_en, acc_clr}, 3'b010);
        at(27);
        check("t27_first_write", {out_we, out_addr}, {1'b1, 8'd0});
        at(73 * 27 + 25);
        check("win73_kidx24", {k_addr0, k_addr1, in_addr}, {8'd49, 8'd124, 10'd209});
        for (int k = 0; k < 5; k++) begin
            at(2100 + k * 600 + $urandom_range(0, 500));
            start = 1'b1;
            at(cur + 1);
            start = 1'b0;
        end
        at(5184);
        check("last_write", {out_we, out_addr}, {1'b1, 8'd191});
        at(5185);
        check("done_t5185", {done, busy}, 2'b11);
        at(5186);
        check("idle_t5186", {done, busy}, 2'b00);
        check("run1_write_count", 64'(run_we), 64'd192);

        // Run 2: start held high for the whole run, dropped in the idle cycle after done.
        repeat ($urandom_range(1, 8)) @(posedge clk);
        #1 start = 1'b1;
        wait_done(6000);
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(negedge clk);
        check("run2_no_restart", {busy, done}, 2'b00);
        check("run2_write_count", 64'(run_we), 64'd192);

        // Run 3: asynchronous reset mid-layer, then a fresh run from address 0.
        start_pulse();
        at(2999);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("reset_midrun_zero", {k_addr0, k_addr1, in_addr, acc_clr, acc_en, out_we, out_addr, busy, done}, 64'd0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (4) @(negedge clk);
        check("no_resume", {55'd0, busy, out_addr}, 64'd0);
        start_pulse();
        at(27);
        check("restart_first_write", {out_we, out_addr}, {1'b1, 8'd0});
        wait_done(6000);
        check("run3_write_count", 64'(run_we), 64'd192);

`ifdef CONV2_SCHED_STALL_EN
        // Run 4: 10-cycle stall mid-MAC (window 10, kidx 9) delays done by 10.
        repeat (3) @(posedge clk);
        start_pulse();
        at(279);
        @(posedge clk); #1 stall = 1'b1;
        at(280);
        check("stall_hold", {k_addr0, acc_en, acc_clr}, {8'd9, 1'b0, 1'b0});
        at(289);
        check("stall_still_hold", {k_addr0, acc_en}, {8'd9, 1'b0});
        @(posedge clk); #1 stall = 1'b0;
        at(5194);
        check("stall_pre_done", {done, out_we, out_addr}, {1'b0, 1'b1, 8'd191});
        at(5195);
        check("stall_done_t5195", {done, busy}, 2'b11);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv2_sched.md
CONV2_SCHED -- requirements
Module: conv2_sched

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-low (reset=0 clears all state immediately).
REQ-003 SHALL have port start, input, 1: one-cycle request to run the full conv2 layer.
REQ-004 SHALL have port k_addr0, output, 8: kernel weight address, port 0.
REQ-005 SHALL have port k_addr1, output, 8: kernel weight address, port 1 (second kernel bank).
REQ-006 SHALL have port in_addr, output, 10: input feature-map read address.
REQ-007 SHALL have port acc_clr, output, 1: clear accumulators before the first product of a window.
REQ-008 SHALL have port acc_en, output, 1: accumulate current memory read data.
REQ-009 SHALL have port out_we, output, 1: write accumulated result.
REQ-010 SHALL have port out_addr, output, 8: result write address.
REQ-011 SHALL have port busy, output, 1: layer in progress.
REQ-012 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-013 SHALL implement an FSM with states IDLE, MAC, DRAIN, WRITE, DONE.
REQ-014 SHALL hold three counters: kidx 0..24 (tracked as kr 0..4 and kc 0..4; no dividers), pos 0..63 (row 0..7, col 0..7), pass 0..2.
REQ-015 IDLE: start=1 SHALL move to MAC with kidx, pos and pass all zero; start in any other state SHALL be ignored.
REQ-016 MAC SHALL last 25 cycles, advancing kidx by 1 per cycle, then go to DRAIN.
REQ-017 In MAC, k_addr0 SHALL equal pass*25+kidx and k_addr1 SHALL equal 75+pass*25+kidx.
REQ-018 In MAC, in_addr SHALL equal pass*144+(row+kr)*12+(col+kc), which addresses three 12x12 input maps.
REQ-019 Memory read latency SHALL be one cycle, so acc_en SHALL be high exactly in the 25 cycles following the MAC address cycles (the last of them is DRAIN).
REQ-020 acc_clr SHALL be high only together with the first acc_en of each window (kidx=0 data).
REQ-021 DRAIN SHALL last 1 cycle and then go to WRITE.
REQ-022 WRITE SHALL last 1 cycle with out_we=1 and out_addr=pass*64+pos.
REQ-023 Leaving WRITE: if pos<63, pos SHALL increment; if pos=63, pos SHALL wrap to 0 and pass SHALL increment.
REQ-024 Leaving WRITE, the next state SHALL be MAC, except after pass=2 and pos=63, when it SHALL be DONE.
REQ-025 DONE SHALL assert done for 1 cycle and then go to IDLE.
REQ-026 busy SHALL be 1 in MAC, DRAIN, WRITE and DONE, and 0 in IDLE.
REQ-027 Each window SHALL take 27 cycles; with start sampled at cycle T0, the first out_we SHALL be at T27, the last out_we at T5184, done at T5185, and idle at T5186.
REQ-028 Outside MAC, address outputs SHALL hold their last value, and acc_en, acc_clr and out_we SHALL be 0 except as stated above.
REQ-029 All outputs SHALL be registered or derived purely from registered state; no combinational path from start.

Reset
REQ-030 reset=0 at any time, including mid-layer, SHALL force IDLE and clear all counters.
REQ-031 During reset, all outputs SHALL be 0: addresses, acc_clr, acc_en, out_we, busy and done.
REQ-032 A partially completed layer SHALL NOT resume after reset; a new start is required.

Configuration
REQ-033 Macro CONV2_SCHED_STALL_EN SHALL, when defined, add input port stall (1 bit).
REQ-034 With CONV2_SCHED_STALL_EN, stall=1 SHALL freeze FSM, counters and the acc pipeline stage, and SHALL force acc_en, acc_clr, out_we and done to 0 while asserted.
REQ-035 With CONV2_SCHED_STALL_EN, the stall-free timing SHALL resume unchanged on the cycle after stall drops.
REQ-036 Without the macro, there SHALL be no stall port and behaviour SHALL be as in REQ-013 to REQ-029.

Verification
REQ-037 Reset then start pulse at T0 -> at T1 k_addr0=0, k_addr1=75, in_addr=0; at T2 acc_clr=acc_en=1; at T27 out_we=1, out_addr=0.
REQ-038 Window pos=9, pass=1 at kidx=24 -> k_addr0=49, k_addr1=124, in_addr=144+(1+4)*12+(1+4)=209.
REQ-039 Full run -> exactly 192 out_we pulses, out_addr 0..191 in order, exactly 25 acc_en per window, done at T5185, busy=0 at T5186.
REQ-040 start held high throughout the run -> single run only; a second run starts only if start=1 in IDLE after done.
REQ-041 reset=0 at T3000 -> all outputs 0 within the same cycle; release and start -> run restarts from out_addr=0.
REQ-042 With CONV2_SCHED_STALL_EN, stall for 10 cycles mid-MAC -> addresses hold and acc_en=0; done at T5195.
